vblank_access_scheduler: RTL and testbench
==========================================

# vblank_access_scheduler

Schedules access to shared game state (tile map, robot position) so it is modified only during vertical blanking. Watches the VGA sync counter's line number and opens an access window at the start of each vertical blank. Inside that window it round-robin arbitrates two requesters, the robot-motion logic and the pipe-cleaning logic. It also produces per-frame and divided game-rate tick strobes. It sits between the VGA sync block and the game logic, all in the 50 MHz domain.

## Interface
- VD, 480: visible lines; window opens when line VD begins
- V_TOTAL, 525: total lines per frame; line V_TOTAL-1 wrapping to 0 ends the window
- GUARD_LINES, 2: new grants are refused from line V_TOTAL-GUARD_LINES onward
- FRAME_DIV, 4: frames per move_tick; range 1..255

- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high; top level drives it from synchronized ~KEY[0]
- pixel_y  in  10  current line from VGA sync
- req  in  2  access request per requester; level, held until granted
- done  in  2  one-cycle pulse from the granted requester to release its grant
- gnt  out  2  one-hot or zero access grant
- window  out  1  high while the access window is open (states ARB, GRANT, CLOSED)
- frame_tick  out  1  one-cycle pulse at window open
- move_tick  out  1  one-cycle pulse, coincident with every FRAME_DIV-th frame_tick
- frame_cnt  out  16  frames since reset, wraps
- overrun  out  1  sticky: a grant was still held at frame wrap

## Operation
- The block registers pixel_y into last_y every cycle.
- open = (pixel_y==VD) && (last_y==VD-1).
- wrap = (pixel_y==0) && (last_y==V_TOTAL-1).
- cutoff = (pixel_y >= V_TOTAL-GUARD_LINES).
- State machine:
  - IDLE: on open -> ARB.
  - ARB: on wrap -> IDLE; else on cutoff -> CLOSED; else if any req -> GRANT, with gnt set to the winner.
  - GRANT: on done[g] for the granted index g -> ARB, gnt=0; on wrap without done -> IDLE, gnt=0, overrun set.
  - CLOSED: on wrap -> IDLE.
- Arbitration:
  - Round-robin with pointer last_g.
  - If only one requester asserts req, it wins.
  - If both assert req, the one with index != last_g wins.
  - last_g updates on each grant.
  - After reset last_g=1, so requester 0 wins the first tie.
- The block ignores done on a non-granted index and done while no grant is held.
- A requester that drops req while granted keeps the grant until it pulses done or wrap occurs.
- Frame and move ticks:
  - On open: frame_tick=1 and frame_cnt+1 (mod 2^16).
  - Divider div counts 0..FRAME_DIV-1 on each open.
  - move_tick=1 when div==FRAME_DIV-1 at open; div then returns to 0.
- overrun clears only on reset.

## Timing
- All outputs are registered.
- Reset values: gnt=0, window=0, frame_tick=0, move_tick=0, frame_cnt=0, overrun=0, state IDLE, div=0, last_y=0, last_g=1.
- A reset mid-grant drops gnt at that edge; no overrun is recorded.
- frame_tick, window and move_tick rise the cycle after the cycle in which open is true.
- Grant latency: req seen in ARB at cycle N gives gnt at N+1.
- Release: done at cycle N drops gnt at N+1, and the state returns to ARB.
  - The earliest next grant is N+2, so at least one idle cycle separates grants.
- done and wrap in the same cycle: treated as a release, with no overrun.
- cutoff and req in the same ARB cycle: cutoff wins, and no grant is issued.
- With FRAME_DIV=1, move_tick accompanies every frame_tick.
- pixel_y changes at most once per 1600 clocks; the block does not depend on p_tick.

## Configuration
- With VBLANK_SCHED_STATS_EN defined:
  - Adds output grant_cnt (16 bits), which counts grants issued since reset and wraps.
  - Adds output overrun_cnt (8 bits), which counts overrun events and saturates at 255.
  - Both reset to 0.
- Without the macro:
  - Neither port nor its counters exist.
  - All other behaviour is identical.

## Structure
- Shared package vga_pkg holds:
  - The line constants VD, V_TOTAL and GUARD_LINES, shared with the VGA sync block.
  - The state enum IDLE/ARB/GRANT/CLOSED.
- One sub-module: rr_arb2, a two-input round-robin picker.
  - Inputs: req[1:0], last_g.
  - Outputs: winner index and a valid flag.
  - Purely combinational; last_g is held in the parent.

## Test plan
- Reset, then sweep pixel_y from 0 to 524 and back to 0:
  - frame_tick pulses once, one cycle after pixel_y becomes 480.
  - frame_cnt reads 1.
  - window is high from that point until the cycle after pixel_y returns to 0.
- req=2'b11 held through the window; each grant is released by done two cycles after it is granted:
  - gnt sequence is 01, 00, 10, 00, 01.
  - Each grant is separated by at least one idle cycle.
- req[0] asserted at line 523 (cutoff with GUARD_LINES=2): gnt stays 0 and the state goes to CLOSED.
- Grant held with no done through the 524 -> 0 wrap: gnt drops the cycle after wrap and overrun=1. The overrun stays at 1 over the next frame.
- 8 frames with FRAME_DIV=4: move_tick pulses at the 4th and 8th frame_ticks only.
- reset asserted while gnt=10 in mid-window: the next cycle shows all outputs 0 and overrun=0. The following tie grants requester 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: line constants shared with the VGA sync block, plus the state type of the
// vertical-blank access scheduler.
//   VD          first line of vertical blank (visible lines 0..VD-1)
//   V_TOTAL     lines per frame
//   GUARD_LINES lines at the end of a frame in which no new grant is issued
package vga_pkg;

  localparam int unsigned Y_W = 10;

  localparam logic [Y_W-1:0] VD          = 10'd480;
  localparam logic [Y_W-1:0] V_TOTAL     = 10'd525;
  localparam logic [Y_W-1:0] GUARD_LINES = 10'd2;

  localparam logic [Y_W-1:0] LAST_LINE   = V_TOTAL - 10'd1;
  localparam logic [Y_W-1:0] CUTOFF_LINE = V_TOTAL - GUARD_LINES;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    GRANT,
    CLOSED
  } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker, purely combinational.
//   req     in  2  requests
//   last_g  in  1  index that won the previous grant (held by the parent)
//   winner  out 1  index of the chosen requester (only meaningful when valid)
//   valid   out 1  at least one request is present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_g,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    unique case (req)
      2'b00: winner = 1'b0;
      2'b01: winner = 1'b0;
      2'b10: winner = 1'b1;
      2'b11: winner = ~last_g;  // tie: whoever did not win last time
    endcase
  end

endmodule

// File: rtl/vblank_access_scheduler.sv
// vblank_access_scheduler: opens an access window on shared game state at the start of each
// vertical blank, round-robin grants it to two requesters inside that window, and produces
// per-frame and divided game-rate tick strobes. Single clock domain (CLOCK_50).
//
// Ports
//   CLOCK_50    in   1  system clock
//   reset       in   1  synchronous, active-high
//   pixel_y     in  10  current line from VGA sync
//   req         in   2  level request per requester, held until granted
//   done        in   2  one-cycle release pulse from the granted requester
//   gnt         out  2  one-hot or zero grant
//   window      out  1  access window open (ARB, GRANT, CLOSED)
//   frame_tick  out  1  pulse at window open
//   move_tick   out  1  pulse on every FRAME_DIV-th frame_tick
//   frame_cnt   out 16  frames since reset, wraps
//   overrun     out  1  sticky: a grant was still held at frame wrap
//
// Optional build macro VBLANK_SCHED_STATS_EN adds:
//   grant_cnt   out 16  grants issued since reset, wraps
//   overrun_cnt out  8  overrun events, saturates at 255
module vblank_access_scheduler #(
  parameter int unsigned FRAME_DIV = 4  // 1..255
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [9:0]  pixel_y,
  input  logic [1:0]  req,
  input  logic [1:0]  done,
  output logic [1:0]  gnt,
  output logic        window,
  output logic        frame_tick,
  output logic        move_tick,
  output logic [15:0] frame_cnt,
  output logic        overrun
`ifdef VBLANK_SCHED_STATS_EN
  ,
  output logic [15:0] grant_cnt,
  output logic [7:0]  overrun_cnt
`endif
);

  import vga_pkg::*;

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  sched_state_e state;
  logic [9:0]   last_y;
  logic         last_g;
  logic [7:0]   div;

  logic open_evt;
  logic wrap_evt;
  logic cutoff;
  logic done_hit;
  logic arb_winner;
  logic arb_valid;

  // Edge detection on the line number: each fires for exactly one line transition.
  assign open_evt = (pixel_y == VD) && (last_y == VD - 10'd1);
  assign wrap_evt = (pixel_y == 10'd0) && (last_y == LAST_LINE);
  assign cutoff   = (pixel_y >= CUTOFF_LINE);

  // gnt is one-hot or zero, so masking done with it ignores stray or unowned pulses.
  assign done_hit = |(done & gnt);

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .last_g (last_g),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      last_y     <= '0;
      last_g     <= 1'b1;
      div        <= '0;
      gnt        <= '0;
      window     <= 1'b0;
      frame_tick <= 1'b0;
      move_tick  <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
`ifdef VBLANK_SCHED_STATS_EN
      grant_cnt   <= '0;
      overrun_cnt <= '0;
`endif
    end else begin
      last_y     <= pixel_y;
      frame_tick <= open_evt;
      move_tick  <= open_evt && (div == DIV_LAST);

      if (open_evt) begin
        frame_cnt <= frame_cnt + 16'd1;
        div       <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
      end

      case (state)
        IDLE: begin
          if (open_evt) begin
            state  <= ARB;
            window <= 1'b1;
          end
        end

        ARB: begin
          if (wrap_evt) begin
            state  <= IDLE;
            window <= 1'b0;
          end else if (cutoff) begin
            // Guard band: too close to the next frame to start a new access.
            state <= CLOSED;
          end else if (arb_valid) begin
            state  <= GRANT;
            gnt    <= arb_winner ? 2'b10 : 2'b01;
            last_g <= arb_winner;
`ifdef VBLANK_SCHED_STATS_EN
            grant_cnt <= grant_cnt + 16'd1;
`endif
          end
        end

        GRANT: begin
          if (done_hit) begin
            gnt <= '0;
            // A release landing on the wrap line still closes the window; it is not an overrun.
            if (wrap_evt) begin
              state  <= IDLE;
              window <= 1'b0;
            end else begin
              state <= ARB;
            end
          end else if (wrap_evt) begin
            gnt     <= '0;
            state   <= IDLE;
            window  <= 1'b0;
            overrun <= 1'b1;
`ifdef VBLANK_SCHED_STATS_EN
            if (overrun_cnt != 8'hFF) begin
              overrun_cnt <= overrun_cnt + 8'd1;
            end
`endif
          end
        end

        CLOSED: begin
          if (wrap_evt) begin
            state  <= IDLE;
            window <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          gnt    <= '0;
          window <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_access_scheduler.sv
// Directed bench for vblank_access_scheduler: expectations are queued when stimulus is driven
// and popped against DUT outputs one cycle later, sampled 1 ns after the rising edge.
module tb_vblank_access_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [9:0]  pixel_y;
  logic [1:0]  req;
  logic [1:0]  done;
  logic [1:0]  gnt;
  logic        window;
  logic        frame_tick;
  logic        move_tick;
  logic [15:0] frame_cnt;
  logic        overrun;
`ifdef VBLANK_SCHED_STATS_EN
  logic [15:0] grant_cnt;
  logic [7:0]  overrun_cnt;
`endif

  vblank_access_scheduler #(
    .FRAME_DIV (4)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .pixel_y    (pixel_y),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .window     (window),
    .frame_tick (frame_tick),
    .move_tick  (move_tick),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun)
`ifdef VBLANK_SCHED_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          vectors = 0;
  int          miscompares = 0;
  int          frames = 0;
  string       tag_q[$];
  logic [15:0] exp_q[$];

  logic [1:0] gnt_seq  [8] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  logic [1:0] done_seq [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic go_line(input int y);
    pixel_y = 10'(y);
    tick();
  endtask

  // From line 0 in IDLE: walk to line 480 and check the open-cycle outputs.
  task automatic open_frame();
    for (int y = 1; y < 480; y++) go_line(y);
    frames++;
    pixel_y = 10'd480;
    expect_val("open_frame_tick", 16'd1);
    expect_val("open_move_tick", {15'd0, (frames % 4) == 0});
    expect_val("open_frame_cnt", 16'(frames));
    expect_val("open_window", 16'd1);
    tick();
    chk({15'd0, frame_tick});
    chk({15'd0, move_tick});
    chk(frame_cnt);
    chk({15'd0, window});
  endtask

  // From line 480: walk to the wrap and check the window closes.
  task automatic close_frame();
    for (int y = 481; y < 525; y++) go_line(y);
    pixel_y = 10'd0;
    expect_val("wrap_window", 16'd0);
    tick();
    chk({15'd0, window});
  endtask

  initial begin
    reset   = 1'b1;
    pixel_y = 10'd0;
    req     = 2'b00;
    done    = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    expect_val("rst_gnt", 16'd0);        chk({14'd0, gnt});
    expect_val("rst_window", 16'd0);     chk({15'd0, window});
    expect_val("rst_frame_tick", 16'd0); chk({15'd0, frame_tick});
    expect_val("rst_move_tick", 16'd0);  chk({15'd0, move_tick});
    expect_val("rst_frame_cnt", 16'd0);  chk(frame_cnt);
    expect_val("rst_overrun", 16'd0);    chk({15'd0, overrun});

    // Full-frame sweep with per-line window / frame_tick checks
    for (int y = 0; y < 525; y++) begin
      pixel_y = 10'(y);
      expect_val("sweep_frame_tick", {15'd0, y == 480});
      expect_val("sweep_window", {15'd0, y >= 480});
      tick();
      chk({15'd0, frame_tick});
      chk({15'd0, window});
    end
    frames = 1;
    pixel_y = 10'd0;
    expect_val("sweep_wrap_window", 16'd0);
    expect_val("sweep_frame_cnt", 16'd1);
    tick();
    chk({15'd0, window});
    chk(frame_cnt);

    // Round-robin with both requesters; one wrong-index done is ignored
    req = 2'b11;
    open_frame();
    for (int i = 0; i < 8; i++) begin
      expect_val("rr_gnt", {14'd0, gnt_seq[i]});
      tick();
      chk({14'd0, gnt});
      done = done_seq[i];
    end
    done = 2'b01;
    tick();
    done = 2'b00;
    req  = 2'b00;
    tick();

    // Request arriving in the guard band is refused
    for (int y = 481; y < 523; y++) go_line(y);
    pixel_y = 10'd523;
    req     = 2'b01;
    expect_val("cutoff_gnt", 16'd0);
    expect_val("cutoff_window", 16'd1);
    tick();
    chk({14'd0, gnt});
    chk({15'd0, window});
    expect_val("closed_gnt", 16'd0);
    tick();
    chk({14'd0, gnt});
    expect_val("closed_524_gnt", 16'd0);
    go_line(524);
    chk({14'd0, gnt});
    req     = 2'b00;
    pixel_y = 10'd0;
    expect_val("closed_wrap_window", 16'd0);
    expect_val("closed_wrap_overrun", 16'd0);
    tick();
    chk({15'd0, window});
    chk({15'd0, overrun});

    // Grant held through the wrap; dropping req does not release it
    req = 2'b01;
    open_frame();
    expect_val("ovr_gnt", 16'd1);
    tick();
    chk({14'd0, gnt});
    req = 2'b00;
    expect_val("ovr_hold_gnt", 16'd1);
    tick();
    chk({14'd0, gnt});
    for (int y = 481; y < 525; y++) go_line(y);
    pixel_y = 10'd0;
    expect_val("ovr_wrap_gnt", 16'd0);
    expect_val("ovr_wrap_overrun", 16'd1);
    expect_val("ovr_wrap_window", 16'd0);
    tick();
    chk({14'd0, gnt});
    chk({15'd0, overrun});
    chk({15'd0, window});
    open_frame();
    close_frame();
    expect_val("ovr_sticky", 16'd1);
    tick();
    chk({15'd0, overrun});

    // Eight more frames: move_tick on every 4th frame_tick, one cycle wide
    for (int f = 0; f < 8; f++) begin
      open_frame();
      expect_val("tick_width_frame", 16'd0);
      expect_val("tick_width_move", 16'd0);
      tick();
      chk({15'd0, frame_tick});
      chk({15'd0, move_tick});
      close_frame();
    end

    // Reset while requester 1 holds the grant
    req = 2'b10;
    open_frame();
    expect_val("pre_rst_gnt", 16'd2);
    tick();
    chk({14'd0, gnt});
    reset = 1'b1;
    expect_val("mid_rst_gnt", 16'd0);
    expect_val("mid_rst_window", 16'd0);
    expect_val("mid_rst_frame_tick", 16'd0);
    expect_val("mid_rst_move_tick", 16'd0);
    expect_val("mid_rst_frame_cnt", 16'd0);
    expect_val("mid_rst_overrun", 16'd0);
    tick();
    chk({14'd0, gnt});
    chk({15'd0, window});
    chk({15'd0, frame_tick});
    chk({15'd0, move_tick});
    chk(frame_cnt);
    chk({15'd0, overrun});
    reset   = 1'b0;
    frames  = 0;
    pixel_y = 10'd0;
    req     = 2'b11;
    tick();
    open_frame();
    expect_val("post_rst_tie_gnt", 16'd1);
    tick();
    chk({14'd0, gnt});
    done = 2'b01;
    tick();
    done = 2'b00;
    req  = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
